multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Moore FSM controller for the multi-cycle RV32I datapath. It replaces the single-cycle combinational decoder.
//  Sequences fetch/decode/execute/memory/writeback over several cycles, sharing one ALU and one unified memory.
//  Supports lw, sw, R-ALU, I-ALU, beq, plus optional bne and jal. Flags illegal opcodes.
//  Sits between the instruction register (op/funct fields) and the datapath enables and mux selects.
// PARAMETERS
//  ALU_CTRL_W      3  width of ALU_Control; codes: add 010, sub 011, or 100, and 101, slt 110, none 000
//  SUPPORT_JAL     1  1: opcode 1101111 decoded; 0: treated as illegal
//  SUPPORT_BNE     1  1: opcode 1100011 with funct3=001 branches on !zero; 0: funct3=001 treated as illegal
//  HALT_ON_ILLEGAL 1  1: illegal opcode parks FSM in TRAP until reset; 0: illegal opcode retires as NOP
// PORTS
//  clk            in   1           rising-edge clock
//  reset          in   1           synchronous, active-high
//  op_code        in   7           instr[6:0], from instruction register
//  funct3         in   3           instr[14:12]
//  funct7_5       in   1           instr[30]
//  zero           in   1           ALU zero flag, same cycle
//  PC_Write       out  1           PC register load enable
//  Adr_Src        out  1           memory address: 0 PC, 1 Result
//  Mem_write      out  1           memory write enable
//  IR_Write       out  1           instruction register / OldPC load enable
//  Result_Src     out  2           00 ALUOut, 01 Data, 10 ALUResult
//  ALU_SrcA       out  2           00 PC, 01 OldPC, 10 rs1 data
//  ALU_SrcB       out  2           00 rs2 data, 01 immediate, 10 constant 4
//  ImmSrc         out  2           00 I, 01 S, 10 B, 11 J; combinational from op_code in every state
//  Reg_write      out  1           register file WE3
//  ALU_Control    out  ALU_CTRL_W  ALU operation code
//  instr_retired  out  1           1-cycle pulse in an instruction's last state
//  illegal_instr  out  1           sticky; set on illegal decode, cleared only by reset
// BEHAVIOUR
//  - Reset: while reset=1, all enables (PC_Write, IR_Write, Mem_write, Reg_write), instr_retired and illegal_instr are 0.
//    All selects and ALU_Control are 0 during reset. The next state is FETCH.
//  - Reset mid-instruction aborts the instruction with no further writes.
//  - States and outputs (unlisted signals are 0):
//      FETCH    Adr_Src=0, IR_Write, SrcA=00, SrcB=10, ALU add, Result_Src=10, PC_Write=1  -> DECODE
//      DECODE   SrcA=01, SrcB=01, ALU add (branch target into ALUOut)
//               -> MEMADR (lw/sw), EXECR, EXECI, BRANCH, JAL, or TRAP/FETCH on illegal
//      MEMADR   SrcA=10, SrcB=01, ALU add  -> MEMREAD (lw) / MEMWRITE (sw)
//      MEMREAD  Adr_Src=1, Result_Src=00  -> MEMWB
//      MEMWB    Result_Src=01, Reg_write, instr_retired  -> FETCH
//      MEMWRITE Adr_Src=1, Result_Src=00, Mem_write, instr_retired  -> FETCH
//      EXECR    SrcA=10, SrcB=00, ALU per funct  -> ALUWB
//      EXECI    SrcA=10, SrcB=01, ALU per funct  -> ALUWB
//      ALUWB    Result_Src=00, Reg_write, instr_retired  -> FETCH
//      BRANCH   SrcA=10, SrcB=00, ALU sub, Result_Src=00, instr_retired
//               PC_Write = (funct3==000 & zero) | (funct3==001 & !zero)  -> FETCH
//      JAL      SrcA=01, SrcB=10, ALU add, Result_Src=00, PC_Write=1  -> ALUWB (rd <= PC+4)
//      TRAP     all enables 0; stays in TRAP until reset
//  - Cycle counts: lw 5, sw 4, R 4, I 4, beq/bne 3, jal 4.
//  - ALU decode (EXECR/EXECI) by funct3:
//      000 -> sub if (op_code[5] & funct7_5), otherwise add
//      010 -> slt;  110 -> or;  111 -> and;  other -> 000 (no write suppression)
//  - Illegal = opcode not in the supported set, or a branch funct3 other than 000 (or 001 when SUPPORT_BNE=1).
//    On detection in DECODE: illegal_instr is set on the next clock edge.
//    HALT_ON_ILLEGAL=1: the FSM goes to TRAP.
//    HALT_ON_ILLEGAL=0: instr_retired pulses in DECODE and the FSM goes to FETCH.
//  - All outputs are combinational from the state register plus the instruction fields; there are no latches.
//    Every case statement has a default.
// STRUCTURE
//  - Package rv_ctrl_pkg holds: state encoding localparams, opcode constants, ALU code constants,
//    and Result_Src/ALU_Src encodings.
//  - One sub-module, alu_decoder (ALU_op, funct3, op_code[5], funct7_5 -> ALU_Control), shared with the single-cycle core.
//  - Top level contains: next-state logic, state register, output decode, and the sticky illegal flag.
// TESTING
//  - Reset: hold reset 2 cycles, release -> first cycle FETCH with IR_Write=1, PC_Write=1, SrcB=10, ALU_Control=010.
//  - lw (op 0000011): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
//    Reg_write=1 only in cycle 5 with Result_Src=01; instr_retired pulses once.
//  - R-type sub (op 0110011, funct3 000, funct7_5=1) -> EXECR gives ALU_Control=011.
//    addi with funct7_5=1 (op 0010011) -> ALU_Control=010.
//  - beq with zero=1 -> PC_Write=1 in cycle 3; beq with zero=0 -> PC_Write=0.
//    bne (funct3 001) with zero=0 -> PC_Write=1.
//  - jal (op 1101111) -> PC_Write in cycle 3 with SrcA=01, SrcB=10; Reg_write in cycle 4 with Result_Src=00.
//  - Illegal op 1111111 with HALT_ON_ILLEGAL=1 -> illegal_instr=1 from cycle 3; no enables for 20 cycles.
//    Then reset -> flag clears and FETCH resumes.
//    Assert reset during MEMWRITE -> Mem_write=0 in that cycle.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I controller:
// FSM states, opcodes, ALU codes and datapath mux selects.
package rv_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        logic [1:0] sel;
        sel = IMM_I;
        case (op)
            OP_STORE:  sel = IMM_S;
            OP_BRANCH: sel = IMM_B;
            OP_JAL:    sel = IMM_J;
            default:   sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU control decoder shared with the single-cycle core:
// maps ALU_op plus funct fields onto an ALU operation code.
module alu_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic [1:0]            i_alu_op,
    input  logic [2:0]            i_funct3,
    input  logic                  i_op5,
    input  logic                  i_funct7_5,
    output logic [ALU_CTRL_W-1:0] o_alu_control
);

    logic [2:0] w_code;

    always_comb begin
        w_code = ALU_NONE;
        case (i_alu_op)
            ALUOP_ADD: w_code = ALU_ADD;
            ALUOP_SUB: w_code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  w_code = (i_op5 & i_funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  w_code = ALU_SLT;
                    3'b110:  w_code = ALU_OR;
                    3'b111:  w_code = ALU_AND;
                    default: w_code = ALU_NONE;
                endcase
            end
            default: w_code = ALU_NONE;
        endcase
    end

    assign o_alu_control = ALU_CTRL_W'(w_code);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM controller for the multi-cycle RV32I datapath
// (fetch/decode/execute/memory/writeback over one ALU and memory).
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W      = 3,
    parameter bit SUPPORT_JAL     = 1'b1,
    parameter bit SUPPORT_BNE     = 1'b1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [6:0]            i_op_code,
    input  logic [2:0]            i_funct3,
    input  logic                  i_funct7_5,
    input  logic                  i_zero,
    output logic                  o_PC_Write,
    output logic                  o_Adr_Src,
    output logic                  o_Mem_write,
    output logic                  o_IR_Write,
    output logic [1:0]            o_Result_Src,
    output logic [1:0]            o_ALU_SrcA,
    output logic [1:0]            o_ALU_SrcB,
    output logic [1:0]            o_ImmSrc,
    output logic                  o_Reg_write,
    output logic [ALU_CTRL_W-1:0] o_ALU_Control,
    output logic                  o_instr_retired,
    output logic                  o_illegal_instr
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_illegal;
    logic                  w_illegal;
    logic                  w_take;
    logic [1:0]            w_alu_op;
    logic [ALU_CTRL_W-1:0] w_alu_ctrl;

    always_comb begin
        w_illegal = 1'b1;
        case (i_op_code)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE: w_illegal = 1'b0;
            OP_BRANCH: w_illegal = !((i_funct3 == F3_BEQ) ||
                                     (SUPPORT_BNE && (i_funct3 == F3_BNE)));
            OP_JAL:  w_illegal = !SUPPORT_JAL;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_take = ((i_funct3 == F3_BEQ) && i_zero) ||
                    (SUPPORT_BNE && (i_funct3 == F3_BNE) && !i_zero);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky: only reset clears a detected illegal instruction
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_illegal <= 1'b0;
        end else if ((r_state == S_DECODE) && w_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                if (w_illegal) begin
                    w_next = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
                end else begin
                    case (i_op_code)
                        OP_LOAD, OP_STORE: w_next = S_MEMADR;
                        OP_RTYPE:  w_next = S_EXECR;
                        OP_ITYPE:  w_next = S_EXECI;
                        OP_BRANCH: w_next = S_BRANCH;
                        OP_JAL:    w_next = S_JAL;
                        default:   w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   w_next = (i_op_code == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        o_PC_Write      = 1'b0;
        o_Adr_Src       = 1'b0;
        o_Mem_write     = 1'b0;
        o_IR_Write      = 1'b0;
        o_Result_Src    = RES_ALUOUT;
        o_ALU_SrcA      = SRCA_PC;
        o_ALU_SrcB      = SRCB_RS2;
        o_ImmSrc        = IMM_I;
        o_Reg_write     = 1'b0;
        o_instr_retired = 1'b0;
        w_alu_op        = ALUOP_NONE;
        if (!i_reset) begin
            o_ImmSrc = imm_sel(i_op_code);
            case (r_state)
                S_FETCH: begin
                    o_IR_Write   = 1'b1;
                    o_PC_Write   = 1'b1;
                    o_ALU_SrcB   = SRCB_FOUR;
                    o_Result_Src = RES_ALURES;
                    w_alu_op     = ALUOP_ADD;
                end
                S_DECODE: begin
                    o_ALU_SrcA      = SRCA_OLDPC;
                    o_ALU_SrcB      = SRCB_IMM;
                    w_alu_op        = ALUOP_ADD;
                    o_instr_retired = w_illegal && !HALT_ON_ILLEGAL;
                end
                S_MEMADR: begin
                    o_ALU_SrcA = SRCA_RS1;
                    o_ALU_SrcB = SRCB_IMM;
                    w_alu_op   = ALUOP_ADD;
                end
                S_MEMREAD: begin
                    o_Adr_Src = 1'b1;
                end
                S_MEMWB: begin
                    o_Result_Src    = RES_DATA;
                    o_Reg_write     = 1'b1;
                    o_instr_retired = 1'b1;
                end
                S_MEMWRITE: begin
                    o_Adr_Src       = 1'b1;
                    o_Mem_write     = 1'b1;
                    o_instr_retired = 1'b1;
                end
                S_EXECR: begin
                    o_ALU_SrcA = SRCA_RS1;
                    w_alu_op   = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    o_ALU_SrcA = SRCA_RS1;
                    o_ALU_SrcB = SRCB_IMM;
                    w_alu_op   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    o_Reg_write     = 1'b1;
                    o_instr_retired = 1'b1;
                end
                S_BRANCH: begin
                    o_ALU_SrcA      = SRCA_RS1;
                    w_alu_op        = ALUOP_SUB;
                    o_PC_Write      = w_take;
                    o_instr_retired = 1'b1;
                end
                S_JAL: begin
                    o_ALU_SrcA = SRCA_OLDPC;
                    o_ALU_SrcB = SRCB_FOUR;
                    w_alu_op   = ALUOP_ADD;
                    o_PC_Write = 1'b1;
                end
                default: begin
                    w_alu_op = ALUOP_NONE;
                end
            endcase
        end
    end

    alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (i_funct3),
        .i_op5         (i_op_code[5]),
        .i_funct7_5    (i_funct7_5),
        .o_alu_control (w_alu_ctrl)
    );

    assign o_ALU_Control   = i_reset ? '0 : w_alu_ctrl;
    assign o_illegal_instr = i_reset ? 1'b0 : r_illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed cases
// plus a random instruction stream against a per-cycle control model.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic       regw;
        logic [2:0] alu;
        logic       ret;
        logic       ill;
    } cw_t;

    localparam int K_LW  = 0;
    localparam int K_SW  = 1;
    localparam int K_R   = 2;
    localparam int K_I   = 3;
    localparam int K_BR  = 4;
    localparam int K_JAL = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       pcw, adr, memw, irw, regw, ret, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    cw_t        obs;

    int nchk = 0;
    int npass = 0;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_op_code       (op),
        .i_funct3        (f3),
        .i_funct7_5      (f7),
        .i_zero          (z),
        .o_PC_Write      (pcw),
        .o_Adr_Src       (adr),
        .o_Mem_write     (memw),
        .o_IR_Write      (irw),
        .o_Result_Src    (res),
        .o_ALU_SrcA      (sa),
        .o_ALU_SrcB      (sb),
        .o_ImmSrc        (imm),
        .o_Reg_write     (regw),
        .o_ALU_Control   (alu),
        .o_instr_retired (ret),
        .o_illegal_instr (ill)
    );

    assign obs = '{pcw, adr, memw, irw, res, sa, sb, imm, regw, alu, ret, ill};

    function automatic logic [1:0] m_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] m_funct(input logic [2:0] ff3,
                                           input logic o5, input logic ff7);
        if (ff3 == 3'b000) return (o5 && ff7) ? 3'b011 : 3'b010;
        if (ff3 == 3'b010) return 3'b110;
        if (ff3 == 3'b110) return 3'b100;
        if (ff3 == 3'b111) return 3'b101;
        return 3'b000;
    endfunction

    function automatic int m_len(input int kind);
        int n [6] = '{5, 4, 4, 4, 3, 4};
        return n[kind];
    endfunction

    // Expected control word for cycle k (1-based) of an instruction
    function automatic cw_t m_cw(input int kind, input int k,
                                 input logic [6:0] o, input logic [2:0] ff3,
                                 input logic ff7, input logic zz);
        cw_t e;
        e = '0;
        e.imm = m_imm(o);
        if (k == 1) begin
            e.pcw = 1; e.irw = 1; e.sb = 2'b10; e.alu = 3'b010; e.res = 2'b10;
        end else if (k == 2) begin
            e.sa = 2'b01; e.sb = 2'b01; e.alu = 3'b010;
        end else if (kind == K_LW || kind == K_SW) begin
            if (k == 3) begin
                e.sa = 2'b10; e.sb = 2'b01; e.alu = 3'b010;
            end else if (k == 4) begin
                e.adr = 1;
                if (kind == K_SW) begin e.memw = 1; e.ret = 1; end
            end else begin
                e.res = 2'b01; e.regw = 1; e.ret = 1;
            end
        end else if (kind == K_R || kind == K_I) begin
            if (k == 3) begin
                e.sa = 2'b10;
                e.sb = (kind == K_I) ? 2'b01 : 2'b00;
                e.alu = m_funct(ff3, o[5], ff7);
            end else begin
                e.regw = 1; e.ret = 1;
            end
        end else if (kind == K_BR) begin
            e.sa = 2'b10; e.alu = 3'b011; e.ret = 1;
            e.pcw = (ff3 == 3'b000 && zz) || (ff3 == 3'b001 && !zz);
        end else begin
            if (k == 3) begin
                e.sa = 2'b01; e.sb = 2'b10; e.alu = 3'b010; e.pcw = 1;
            end else begin
                e.regw = 1; e.ret = 1;
            end
        end
        return e;
    endfunction

    task automatic chk(input cw_t e, input string tag);
        nchk++;
        assert (obs === e) npass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    endtask

    // Runs up to lim cycles of one instruction; zmode 2 = random zero flag
    task automatic run(input int kind, input logic [6:0] o, input logic [2:0] ff3,
                       input logic ff7, input int zmode, input int lim,
                       input string tag);
        int n;
        n = m_len(kind);
        if (lim < n) n = lim;
        for (int k = 1; k <= n; k++) begin
            op = o; f3 = ff3; f7 = ff7;
            z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            @(negedge clk);
            chk(m_cw(kind, k, o, ff3, ff7, z), $sformatf("%s_c%0d", tag, k));
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int cyc, input string tag);
        rst = 1'b1;
        for (int i = 0; i < cyc; i++) begin
            z = 1'($urandom);
            @(negedge clk);
            chk('0, tag);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        cw_t e;
        int kind;
        logic [6:0] ro;
        logic [2:0] rf3;
        logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                               7'b0010011, 7'b1100011, 7'b1101111};
        rst = 1'b1; op = '0; f3 = '0; f7 = 1'b0; z = 1'b0;
        @(posedge clk); #1;
        do_reset(2, "reset");

        run(K_LW,  7'b0000011, 3'b010, 1'b0, 2, 9, "lw");
        run(K_R,   7'b0110011, 3'b000, 1'b1, 2, 9, "sub");
        run(K_I,   7'b0010011, 3'b000, 1'b1, 2, 9, "addi_f7");
        run(K_R,   7'b0110011, 3'b110, 1'b0, 2, 9, "or");
        run(K_I,   7'b0010011, 3'b111, 1'b0, 2, 9, "andi");
        run(K_R,   7'b0110011, 3'b010, 1'b0, 2, 9, "slt");
        run(K_R,   7'b0110011, 3'b100, 1'b0, 2, 9, "xor_none");
        run(K_BR,  7'b1100011, 3'b000, 1'b1, 1, 9, "beq_z1");
        run(K_BR,  7'b1100011, 3'b000, 1'b0, 0, 9, "beq_z0");
        run(K_BR,  7'b1100011, 3'b001, 1'b0, 0, 9, "bne_z0");
        run(K_BR,  7'b1100011, 3'b001, 1'b0, 1, 9, "bne_z1");
        run(K_JAL, 7'b1101111, 3'b000, 1'b0, 2, 9, "jal");
        run(K_SW,  7'b0100011, 3'b010, 1'b0, 2, 9, "sw");

        // Illegal opcode traps with the sticky flag and no enables
        run(K_LW, 7'b1111111, 3'b000, 1'b0, 2, 2, "illop");
        for (int i = 0; i < 20; i++) begin
            z = 1'($urandom);
            @(negedge clk);
            e = '0; e.ill = 1'b1; e.imm = m_imm(7'b1111111);
            chk(e, "trap_hold");
            @(posedge clk); #1;
        end
        do_reset(2, "trap_reset");
        run(K_I, 7'b0010011, 3'b110, 1'b0, 2, 9, "after_trap");

        // Branch with unsupported funct3 is illegal too
        run(K_BR, 7'b1100011, 3'b100, 1'b0, 2, 2, "illbr");
        @(negedge clk);
        e = '0; e.ill = 1'b1; e.imm = 2'b10;
        chk(e, "illbr_trap");
        @(posedge clk); #1;
        do_reset(1, "illbr_reset");

        // Reset asserted in MEMWRITE aborts the store
        run(K_SW, 7'b0100011, 3'b010, 1'b0, 2, 3, "sw_abort");
        do_reset(1, "rst_memwrite");
        run(K_LW, 7'b0000011, 3'b010, 1'b0, 2, 9, "lw_after_abort");

        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(0, 5));
            ro = ops[kind];
            rf3 = 3'($urandom);
            if (kind == K_BR) rf3 = {2'b00, 1'($urandom)};
            run(kind, ro, rf3, 1'($urandom), 2, 9, $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
